div_seq_ctrl: RTL and testbench

- Multi-cycle divide controller for the CPU's DIV/DIVU instructions.
- Replaces the single-shot combinational divider with a sequenced restoring divider that retires one quotient bit per clock.
- Provides a start/busy/done handshake so the pipeline control can stall on busy and write HI/LO on done.
- Handles signed operand conditioning, sign fix-up and divide-by-zero.

---
 rtl/div_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_div_seq_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - sequenced restoring divider for DIV/DIVU, one quotient bit per clock
// Optional early-out when |dividend| < |divisor|: define DIV_EARLY_OUT_EN.
module div_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic               dbz_q, dbz_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH-1:0]   rem_sub;
  logic               step_ge;

  always_comb begin
    a_neg = is_signed & dividend[WIDTH-1];
    b_neg = is_signed & divisor[WIDTH-1];
    a_mag = a_neg ? -dividend : dividend;
    b_mag = b_neg ? -divisor : divisor;
  end

  // The shifted partial remainder can exceed WIDTH bits, so compare at WIDTH+1.
  always_comb begin
    rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
    step_ge   = rem_shift >= {1'b0, dvsr_q};
    rem_sub   = rem_shift[WIDTH-1:0] - dvsr_q;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dbz_d  = 1'b0;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          dvsr_d = b_mag;
          acc_d  = {{WIDTH{1'b0}}, a_mag};
          cnt_d  = '0;
          if (divisor == '0) begin
            state_d = S_DONE;
            q_d     = '1;
            r_d     = dividend;
            dbz_d   = 1'b1;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (a_mag < b_mag) begin
            state_d = S_DONE;
            q_d     = '0;
            r_d     = dividend;
          end
`endif
          else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        acc_d = {(step_ge ? rem_sub : rem_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], step_ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) state_d = S_FIX;
      end
      S_FIX: begin
        q_d     = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        r_d     = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == S_RUN) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign q           = q_q;
  assign r           = r_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb/tb_div_seq_ctrl.sv - self-checking bench for div_seq_ctrl against an arithmetic reference model
module tb_div_seq_ctrl;
  localparam int W = 32;
  localparam int FULL_LAT = W + 1;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, start, is_signed;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] q, r;
  int           tests = 0;
  int           fails = 0;

  always #5 clk = ~clk;

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .q(q), .r(r), .div_by_zero(div_by_zero)
  );

  // Reference: plain 64-bit integer division (truncating, remainder follows dividend).
  // Latency is counted as the index of the edge after E0 whose following cycle shows done.
  task automatic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] eq, output logic [W-1:0] er, output logic ez,
                       output int elat, output int ebusy);
    longint sa, sb, ma, mb;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    if (b == '0) begin
      eq = '1; er = a; ez = 1'b1; elat = 0; ebusy = 0;
    end else begin
      eq = W'(sa / sb); er = W'(sa % sb); ez = 1'b0;
      if (EARLY_EN && (ma < mb)) begin elat = 0; ebusy = 0; end
      else begin elat = FULL_LAT; ebusy = FULL_LAT; end
    end
  endtask

  // Issues one divide; with noise, inputs (including start) are scrambled while the op is in flight.
  task automatic do_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input bit noise,
                        output logic [W-1:0] oq, output logic [W-1:0] orr, output logic oz,
                        output int olat, output int obusy, output bit odone_low);
    int n;
    bit seen;
    @(negedge clk);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    olat = -1; obusy = 0; seen = 1'b0; n = 0;
    while (!seen && n < 100) begin
      if (busy) obusy++;
      if (done) begin
        seen = 1'b1;
        olat = n;
      end else begin
        if (noise) begin
          start = 1'($urandom_range(0, 1));
          is_signed = 1'($urandom_range(0, 1));
          dividend = $urandom;
          divisor = $urandom;
        end
        @(posedge clk); #1;
        n++;
      end
    end
    start = 1'b0;
    oq = q; orr = r; oz = div_by_zero;
    @(posedge clk); #1;
    odone_low = !done;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b expected 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset done: got %b expected 0", done); end
    tests++; if (q !== '0) begin fails++; $display("FAIL reset q: got %h expected 0", q); end
    tests++; if (r !== '0) begin fails++; $display("FAIL reset r: got %h expected 0", r); end
    tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL reset dbz: got %b expected 0", div_by_zero); end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    logic [W-1:0] gq, gr; logic gz; int glat, gbusy; bit glow;
    do_div(1'b0, 32'd100, 32'd7, 1'b0, gq, gr, gz, glat, gbusy, glow);
    tests++; if (gq !== 32'd14) begin fails++; $display("FAIL divu_100_7 q: got %h expected %h", gq, 32'd14); end
    tests++; if (gr !== 32'd2) begin fails++; $display("FAIL divu_100_7 r: got %h expected %h", gr, 32'd2); end
    tests++; if (gz !== 1'b0) begin fails++; $display("FAIL divu_100_7 dbz: got %b expected 0", gz); end
    tests++; if (glat != FULL_LAT) begin fails++; $display("FAIL divu_100_7 latency: got %0d expected %0d", glat, FULL_LAT); end
    tests++; if (gbusy != FULL_LAT) begin fails++; $display("FAIL divu_100_7 busy cycles: got %0d expected %0d", gbusy, FULL_LAT); end
    tests++; if (!glow) begin fails++; $display("FAIL divu_100_7 done width: got >1 expected 1 cycle"); end
    tests++; if (q !== 32'd14) begin fails++; $display("FAIL divu_100_7 q hold: got %h expected %h", q, 32'd14); end
  endtask

  task automatic test_signed;
    logic [W-1:0] gq, gr; logic gz; int glat, gbusy; bit glow;
    do_div(1'b1, 32'hFFFF_FFF9, 32'h2, 1'b0, gq, gr, gz, glat, gbusy, glow);
    tests++; if (gq !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_m7_2 q: got %h expected FFFFFFFD", gq); end
    tests++; if (gr !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_m7_2 r: got %h expected FFFFFFFF", gr); end
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, gq, gr, gz, glat, gbusy, glow);
    tests++; if (gq !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_7_m2 q: got %h expected FFFFFFFD", gq); end
    tests++; if (gr !== 32'h1) begin fails++; $display("FAIL div_7_m2 r: got %h expected 00000001", gr); end
  endtask

  task automatic test_div_zero;
    logic [W-1:0] gq, gr; logic gz; int glat, gbusy; bit glow;
    do_div(1'b0, 32'h1234, 32'h0, 1'b0, gq, gr, gz, glat, gbusy, glow);
    tests++; if (gz !== 1'b1) begin fails++; $display("FAIL dbz flag: got %b expected 1", gz); end
    tests++; if (gq !== 32'hFFFF_FFFF) begin fails++; $display("FAIL dbz q: got %h expected FFFFFFFF", gq); end
    tests++; if (gr !== 32'h1234) begin fails++; $display("FAIL dbz r: got %h expected 00001234", gr); end
    tests++; if (glat != 0) begin fails++; $display("FAIL dbz latency: got %0d expected 0", glat); end
    tests++; if (gbusy != 0) begin fails++; $display("FAIL dbz busy cycles: got %0d expected 0", gbusy); end
    tests++; if (!glow) begin fails++; $display("FAIL dbz done width: got >1 expected 1 cycle"); end
    tests++; if (div_by_zero !== 1'b1) begin fails++; $display("FAIL dbz hold: got %b expected 1", div_by_zero); end
    do_div(1'b0, 32'd10, 32'd3, 1'b0, gq, gr, gz, glat, gbusy, glow);
    tests++; if (gz !== 1'b0) begin fails++; $display("FAIL dbz clear: got %b expected 0", gz); end
    tests++; if (gq !== 32'd3 || gr !== 32'd1) begin fails++; $display("FAIL after_dbz q/r: got %h/%h expected 3/1", gq, gr); end
  endtask

  task automatic test_overflow;
    logic [W-1:0] gq, gr; logic gz; int glat, gbusy; bit glow;
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, gq, gr, gz, glat, gbusy, glow);
    tests++; if (gq !== 32'h8000_0000) begin fails++; $display("FAIL ovf q: got %h expected 80000000", gq); end
    tests++; if (gr !== 32'h0) begin fails++; $display("FAIL ovf r: got %h expected 0", gr); end
    tests++; if (gz !== 1'b0) begin fails++; $display("FAIL ovf dbz: got %b expected 0", gz); end
    do_div(1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0, gq, gr, gz, glat, gbusy, glow);
    tests++; if (gq !== 32'hFFFF_FFFF) begin fails++; $display("FAIL divu_max_1 q: got %h expected FFFFFFFF", gq); end
    tests++; if (gr !== 32'h0) begin fails++; $display("FAIL divu_max_1 r: got %h expected 0", gr); end
  endtask

  task automatic test_reset_midrun;
    logic [W-1:0] gq, gr; logic gz; int glat, gbusy; bit glow;
    bit saw_done;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrun_reset busy: got %b expected 0", busy); end
    tests++; if (q !== '0 || r !== '0) begin fails++; $display("FAIL midrun_reset q/r: got %h/%h expected 0/0", q, r); end
    saw_done = done;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    tests++; if (saw_done) begin fails++; $display("FAIL midrun_reset done pulse: got 1 expected none"); end
    do_div(1'b0, 32'd1000, 32'd7, 1'b1, gq, gr, gz, glat, gbusy, glow);
    tests++; if (gq !== 32'd142 || gr !== 32'd6) begin fails++; $display("FAIL after_reset q/r: got %h/%h expected 8e/6", gq, gr); end
    tests++; if (glat != FULL_LAT) begin fails++; $display("FAIL after_reset latency: got %0d expected %0d", glat, FULL_LAT); end
  endtask

  task automatic test_early;
    logic [W-1:0] gq, gr; logic gz; int glat, gbusy; bit glow;
    int xlat;
    xlat = EARLY_EN ? 0 : FULL_LAT;
    do_div(1'b0, 32'd5, 32'd9, 1'b0, gq, gr, gz, glat, gbusy, glow);
    tests++; if (gq !== 32'd0 || gr !== 32'd5) begin fails++; $display("FAIL divu_5_9 q/r: got %h/%h expected 0/5", gq, gr); end
    tests++; if (glat != xlat) begin fails++; $display("FAIL divu_5_9 latency: got %0d expected %0d", glat, xlat); end
    tests++; if (gbusy != xlat) begin fails++; $display("FAIL divu_5_9 busy cycles: got %0d expected %0d", gbusy, xlat); end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, gq, gr, eq, er; logic s, gz, ez; int glat, gbusy, elat, ebusy; bit glow;
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = W'($urandom_range(1, 300));
        2: b = '0;
        default: begin b = $urandom; a = W'($urandom_range(0, 50)); end
      endcase
      model(s, a, b, eq, er, ez, elat, ebusy);
      do_div(s, a, b, 1'b1, gq, gr, gz, glat, gbusy, glow);
      tests++;
      if (gq !== eq || gr !== er || gz !== ez) begin
        fails++;
        $display("FAIL rand[%0d] s=%b %h/%h: got q=%h r=%h z=%b expected q=%h r=%h z=%b", i, s, a, b, gq, gr, gz, eq, er, ez);
      end
      tests++;
      if (glat != elat || gbusy != ebusy || !glow) begin
        fails++;
        $display("FAIL rand[%0d] timing: got lat=%0d busy=%0d single=%b expected lat=%0d busy=%0d single=1", i, glat, gbusy, glow, elat, ebusy);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_signed;
    test_div_zero;
    test_overflow;
    test_reset_midrun;
    test_early;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
